// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage: data-memory handshake, upstream stall, MEM/WB result register
// Optional stall-cycle counter enabled by defining MEM_STALL_CNT_EN.
module mem_wb_stage #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              em_valid,
    input  logic              dREN_out,
    input  logic              dWEN_out,
    input  logic [WORD_W-1:0] alu_portOut_out,
    input  logic [WORD_W-1:0] rdat2_out,
    input  logic [WORD_W-1:0] pcplusfour_out,
    input  logic [4:0]        wsel_out,
    input  logic              RegWr_out,
    input  logic              MemtoReg_out,
    input  logic              jal_s_out,
    input  logic              halt_out,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              wb_RegWr,
    output logic [4:0]        wb_wsel,
    output logic [WORD_W-1:0] wb_wdat,
    output logic              halt
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    logic   memop;
    logic   retire_halt;

    // nRST gates the requests so they drop the instant reset asserts, not at the next edge.
    assign memop       = nRST & em_valid & (dREN_out | dWEN_out) & ~halt;
    assign dmemREN     = memop & dREN_out;
    assign dmemWEN     = memop & dWEN_out & ~dREN_out;
    assign dmemaddr    = alu_portOut_out;
    assign dmemstore   = rdat2_out;
    assign mem_stall   = memop & ~dhit;
    assign halt        = (state == HALTED);
    assign retire_halt = em_valid & halt_out & ~mem_stall & ~halt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (retire_halt)
                        state <= HALTED;
                    else if (memop && !dhit)
                        state <= ACCESS;
                end
                ACCESS: begin
                    if (retire_halt)
                        state <= HALTED;
                    else if (dhit || !memop)
                        state <= IDLE;
                end
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // A stalled access, a bubble or a halted core retires nothing; wsel/wdat keep their last value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_RegWr <= 1'b0;
            wb_wsel  <= '0;
            wb_wdat  <= '0;
        end else if (mem_stall || !em_valid || halt) begin
            wb_RegWr <= 1'b0;
        end else begin
            wb_RegWr <= RegWr_out;
            wb_wsel  <= wsel_out;
            if (jal_s_out)
                wb_wdat <= pcplusfour_out;
            else if (MemtoReg_out)
                wb_wdat <= dmemload;
            else
                wb_wdat <= alu_portOut_out;
        end
    end

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            stall_cnt <= '0;
        else if (mem_stall && !halt && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage against a transaction model
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        em_valid, dREN_out, dWEN_out;
    logic [31:0] alu_portOut_out, rdat2_out, pcplusfour_out;
    logic [4:0]  wsel_out;
    logic        RegWr_out, MemtoReg_out, jal_s_out, halt_out, dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_stall, wb_RegWr, halt;
    logic [31:0] dmemaddr, dmemstore, wb_wdat;
    logic [4:0]  wb_wsel;
    logic [31:0] stall_cnt;

    mem_wb_stage #(.WORD_W(32), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .em_valid(em_valid), .dREN_out(dREN_out), .dWEN_out(dWEN_out),
        .alu_portOut_out(alu_portOut_out), .rdat2_out(rdat2_out), .pcplusfour_out(pcplusfour_out),
        .wsel_out(wsel_out), .RegWr_out(RegWr_out), .MemtoReg_out(MemtoReg_out),
        .jal_s_out(jal_s_out), .halt_out(halt_out), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .wb_RegWr(wb_RegWr), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .halt(halt)
`ifdef MEM_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

`ifndef MEM_STALL_CNT_EN
    assign stall_cnt = 32'd0;
`endif

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: what the write-back side should hold after each edge
    bit          m_halt;
    bit          m_rw;
    logic [4:0]  m_ws;
    logic [31:0] m_wd;
    longint      m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halt = 0; m_rw = 0; m_ws = 0; m_wd = 0; m_cnt = 0;
    endtask

    task automatic check_reg_outputs(input string tag);
        check_eq({tag, ".wb_RegWr"}, wb_RegWr, m_rw);
        check_eq({tag, ".wb_wsel"},  wb_wsel,  m_ws);
        check_eq({tag, ".wb_wdat"},  wb_wdat,  m_wd);
        check_eq({tag, ".halt"},     halt,     m_halt);
`ifdef MEM_STALL_CNT_EN
        check_eq({tag, ".stall_cnt"}, stall_cnt, m_cnt);
`endif
    endtask

    task automatic idle_inputs();
        em_valid = 0; dREN_out = 0; dWEN_out = 0; RegWr_out = 0; MemtoReg_out = 0;
        jal_s_out = 0; halt_out = 0; dhit = 0;
    endtask

    // One instruction held in EX/MEM until it retires. lat = cycles before dhit (0 = zero-wait).
    // abort_at >= 0 pulls nRST low asynchronously in that cycle of the access.
    task automatic run_instr(input bit v, input bit ren, input bit wen, input bit rw, input bit m2r,
                             input bit jal, input bit hlt, input logic [4:0] ws,
                             input logic [31:0] alu, input logic [31:0] st, input logic [31:0] pc4,
                             input logic [31:0] ld, input int lat, input int abort_at);
        bit          memop;
        bit          stall;
        int          ncyc;
        logic [31:0] dl;
        memop = v && (ren || wen) && !m_halt;
        ncyc  = memop ? lat : 0;
        for (int k = 0; k <= ncyc; k++) begin
            dl = (memop && k < lat) ? $urandom : ld;
            stall = memop && (k < lat);
            em_valid = v; dREN_out = ren; dWEN_out = wen; RegWr_out = rw; MemtoReg_out = m2r;
            jal_s_out = jal; halt_out = hlt; wsel_out = ws; alu_portOut_out = alu;
            rdat2_out = st; pcplusfour_out = pc4; dmemload = dl;
            dhit = memop ? (k == lat) : 1'($urandom_range(0, 1));
            #3;
            check_eq("dmemREN",   dmemREN,   memop && ren);
            check_eq("dmemWEN",   dmemWEN,   memop && wen && !ren);
            check_eq("dmemaddr",  dmemaddr,  alu);
            check_eq("dmemstore", dmemstore, st);
            check_eq("mem_stall", mem_stall, stall);
            if (k == abort_at) begin
                nRST = 0;
                #1;
                model_reset();
                check_eq("rst.dmemREN",   dmemREN,   0);
                check_eq("rst.mem_stall", mem_stall, 0);
                check_reg_outputs("rst");
                idle_inputs();
                #1 nRST = 1;
                break;
            end
            @(posedge CLK);
            #1;
            if (stall) begin
                m_rw = 0;
                if (!m_halt && m_cnt != 64'hFFFF_FFFF) m_cnt++;
            end else if (m_halt || !v) begin
                m_rw = 0;
            end else begin
                m_rw = rw;
                m_ws = ws;
                m_wd = jal ? pc4 : (m2r ? dl : alu);
                if (hlt) m_halt = 1;
            end
            check_reg_outputs("wb");
        end
    endtask

    task automatic sync_reset();
        nRST = 0;
        #1;
        model_reset();
        check_reg_outputs("sync_rst");
        #1 nRST = 1;
    endtask

    initial begin
        bit v, ren, wen, rw, m2r, jal, hlt;
        int lat;
        nRST = 0;
        idle_inputs();
        wsel_out = 0; alu_portOut_out = 0; rdat2_out = 0; pcplusfour_out = 0; dmemload = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_reg_outputs("reset");
        check_eq("reset.mem_stall", mem_stall, 0);
        nRST = 1;

        // ALU op, register write
        run_instr(1, 0, 0, 1, 0, 0, 0, 5'd5, 32'h1234, 0, 0, 0, 0, -1);
        check_eq("alu.wdat", wb_wdat, 32'h1234);
        // load with three wait cycles
        run_instr(1, 1, 0, 1, 1, 0, 0, 5'd7, 32'h100, 0, 0, 32'hDEADBEEF, 3, -1);
        check_eq("load.wdat", wb_wdat, 32'hDEADBEEF);
        // store with zero-wait hit
        run_instr(1, 0, 1, 0, 0, 0, 0, 5'd3, 32'h200, 32'hCAFE, 0, 0, 0, -1);
        // both read and write set: read wins
        run_instr(1, 1, 1, 1, 1, 0, 0, 5'd9, 32'h300, 32'h55, 0, 32'h77, 1, -1);
        // jal link value
        run_instr(1, 0, 0, 1, 0, 1, 0, 5'd31, 32'h9, 0, 32'h44, 0, 0, -1);
        check_eq("jal.wsel", wb_wsel, 31);
        // r0 write passes through; bubble with junk fields
        run_instr(1, 0, 0, 1, 0, 0, 0, 5'd0, 32'hABCD, 0, 0, 0, 0, -1);
        run_instr(0, 1, 0, 1, 1, 0, 0, 5'd4, 32'h400, 0, 0, 32'h1, 2, -1);
        // halt then a load that must be ignored
        run_instr(1, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0, 0, 0, 0, -1);
        check_eq("halt.set", halt, 1);
        run_instr(1, 1, 0, 1, 1, 0, 0, 5'd2, 32'h500, 0, 0, 32'h2, 2, -1);
        sync_reset();
        // reset in the middle of an access, then count four stalls
        run_instr(1, 1, 0, 1, 1, 0, 0, 5'd6, 32'h600, 0, 0, 32'h3, 5, 2);
        run_instr(1, 1, 0, 1, 1, 0, 0, 5'd8, 32'h700, 0, 0, 32'h4, 4, -1);
`ifdef MEM_STALL_CNT_EN
        check_eq("cnt.four", stall_cnt, 4);
`endif

        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 7) != 0);
            ren = ($urandom_range(0, 2) == 0);
            wen = ($urandom_range(0, 2) == 0);
            rw  = $urandom_range(0, 1);
            m2r = $urandom_range(0, 1);
            jal = ($urandom_range(0, 5) == 0);
            hlt = ($urandom_range(0, 29) == 0);
            lat = $urandom_range(0, 3);
            run_instr(v, ren, wen, rw, m2r, jal, hlt, 5'($urandom), $urandom, $urandom,
                      $urandom, $urandom, lat, ($urandom_range(0, 49) == 0) ? 0 : -1);
            if (m_halt && $urandom_range(0, 3) == 0) sync_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
